// File: rtl/icache.sv
// icache: direct-mapped instruction cache, one 32-bit word per line, one outstanding miss.
// Hits answer one cycle after acceptance; misses hold a fetch request until mc_done.
module icache #(
   parameter int INDEX_BITS = 8,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              clr,
   input  logic              if_valid,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              if_ready,
   output logic              inst_valid,
   output logic [31:0]       inst,
   output logic              mc_fet_ena,
   output logic [ADDR_W-1:0] mc_addr,
   input  logic [31:0]       mc_data,
   input  logic              mc_done
);
   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;
   localparam logic IDLE = 1'b0;
   localparam logic MISS = 1'b1;

   logic                  state_q, state_d;
   logic                  cancel_q, cancel_d;
   logic                  inst_valid_q, inst_valid_d;
   logic [31:0]           inst_q, inst_d;
   logic [ADDR_W-3:0]     req_q, req_d;
   logic [LINES-1:0]      valid_q;
   logic [TAG_W-1:0]      tag_q [LINES];
   logic [31:0]           data_q [LINES];
   logic [INDEX_BITS-1:0] pc_idx, req_idx;
   logic [TAG_W-1:0]      pc_tag, req_tag;
   logic                  accept, hit, fill, deliver, unused_pc;

   assign pc_idx     = if_pc[INDEX_BITS+1:2];
   assign pc_tag     = if_pc[ADDR_W-1:INDEX_BITS+2];
   assign req_idx    = req_q[INDEX_BITS-1:0];
   assign req_tag    = req_q[ADDR_W-3:INDEX_BITS];
   assign unused_pc  = ^if_pc[1:0];
   assign if_ready   = state_q == IDLE;
   assign mc_fet_ena = state_q == MISS;
   assign mc_addr    = {req_q, 2'b00};
   assign inst_valid = inst_valid_q;
   assign inst       = inst_q;

   always_comb begin
      accept       = if_valid && state_q == IDLE && !clr;
      hit          = valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
      fill         = state_q == MISS && mc_done;
      deliver      = fill && !cancel_q && !clr;
      state_d      = fill ? IDLE : (accept && !hit) ? MISS : state_q;
      req_d        = (accept && !hit) ? if_pc[ADDR_W-1:2] : req_q;
      cancel_d     = state_q == MISS && !mc_done && (cancel_q || clr);
      inst_valid_d = (accept && hit) || deliver;
      inst_d       = (accept && hit) ? data_q[pc_idx] : deliver ? mc_data : inst_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cancel_q     <= 1'b0;
         inst_valid_q <= 1'b0;
         inst_q       <= '0;
         req_q        <= '0;
         valid_q      <= '0;
      end else if (rdy) begin
         state_q      <= state_d;
         cancel_q     <= cancel_d;
         inst_valid_q <= inst_valid_d;
         inst_q       <= inst_d;
         req_q        <= req_d;
         if (fill) valid_q[req_idx] <= 1'b1;
      end
   end

   // The fill completes even when cancelled: the memory controller cannot be aborted.
   always_ff @(posedge clk) begin
      if (!rst && rdy && fill) begin
         tag_q[req_idx]  <= req_tag;
         data_q[req_idx] <= mc_data;
      end
   end
endmodule
